// File: rtl/pattern_det_seq.sv
// -----------------------------------------------------------------------------
// pattern_det_seq
//
// Purpose:
//   Serial bit-pattern detector for sync-word spotting on a serial line.
//   Accepted bits (en=1) shift into a history register. When the most recent
//   PAT_W accepted bits equal the currently loaded pattern, a one-cycle
//   registered pulse is raised on y. The first bit received is the pattern MSB.
//
//   The detector supports overlapping and non-overlapping detection. The
//   pattern can be reloaded at run time. A saturating counter tracks the
//   number of matches.
//
// Parameters:
//   PAT_W    pattern length in bits (>= 2)
//   CNT_W    width of match_cnt
//   DEF_PAT  pattern loaded on reset
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         qualifies x; x is only sampled on an edge where en=1
//   x          serial data bit
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   pat_ld     load pat_in as the new pattern and restart detection
//   pat_in     new pattern value
//   cnt_clr    synchronous clear of match_cnt
//   y          registered match pulse
//   match_cnt  saturating match count
// -----------------------------------------------------------------------------
module pattern_det_seq #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = 4'b1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  // Fill counter only needs to reach PAT_W-1.
  localparam int FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_ARMED = 1'b1;

  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] nxt;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_next;
  logic [0:0]       state;
  logic             accept;
  logic             match;
  logic             hit;

  assign nxt    = {hist[PAT_W-2:0], x};
  assign accept = en && !pat_ld;
  // ARMED means PAT_W-1 bits are already held, so the incoming bit completes a window.
  assign match  = (state == S_ARMED) && (nxt == pattern);
  assign hit    = accept && match;

  // A non-overlapping match restarts the fill so no history bit is reused.
  always_comb begin
    fill_next = fill;
    if (hit && !overlap) begin
      fill_next = '0;
    end else if (fill != FILL_MAX) begin
      fill_next = fill + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= DEF_PAT;
      hist    <= '0;
      fill    <= '0;
      state   <= S_FILL;
      y       <= 1'b0;
    end else if (pat_ld) begin
      pattern <= pat_in;
      hist    <= '0;
      fill    <= '0;
      state   <= S_FILL;
      y       <= 1'b0;
    end else if (en) begin
      hist  <= nxt;
      fill  <= fill_next;
      state <= (fill_next == FILL_MAX) ? S_ARMED : S_FILL;
      y     <= match;
    end else begin
      y <= 1'b0;
    end
  end

  // A clear that coincides with a match leaves the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= hit ? CNT_W'(1) : '0;
    end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule
